// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types, defaults and round-robin pick helper for the button event arbiter
package btn_pkg;

    localparam int BTN_MAX        = 16;
    localparam int BTN_N_DEF      = 5;
    localparam int REPEAT_DLY_DEF = 50000000;
    localparam int REPEAT_PER_DEF = 10000000;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       any;
        logic [3:0] idx;
    } rr_pick_t;

    // First set bit starting at ptr, wrapping at n by compare-and-subtract.
    function automatic rr_pick_t rr_pick(input logic [BTN_MAX-1:0] pend,
                                         input logic [3:0] ptr,
                                         input int n);
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = BTN_MAX - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) begin
                    j = j - n;
                end
                if (pend[j[3:0]]) begin
                    r.any = 1'b1;
                    r.idx = j[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_repeat_timer.sv
// rtl/btn_repeat_timer.sv - per-button hold timer producing auto-repeat request pulses
module btn_repeat_timer #(
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rep_pulse
);
    localparam int CW = $clog2(REPEAT_DLY);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        rep_pulse = level && (cnt_q == CW'(REPEAT_DLY - 1));
        cnt_d     = cnt_q;
        if (!level) begin
            cnt_d = '0;
        end else if (rep_pulse) begin
            cnt_d = CW'(REPEAT_DLY - REPEAT_PER);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - latches button presses as pending requests and serialises them round-robin
// into a valid/ready id stream; define BTN_REPEAT_EN for auto-repeat of held buttons.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter  int N_BTN      = BTN_N_DEF,
    parameter  int REPEAT_DLY = REPEAT_DLY_DEF,
    parameter  int REPEAT_PER = REPEAT_PER_DEF,
    localparam int ID_W       = $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic [N_BTN-1:0] pending,
    output logic             evt_overrun,
    output logic [7:0]       ovr_cnt
);
    arb_state_e        state_q, state_d;
    logic              evt_valid_q, evt_valid_d;
    logic [ID_W-1:0]   evt_id_q, evt_id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_BTN-1:0]  pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        ovr_cnt_q, ovr_cnt_d;

    logic [N_BTN-1:0]   req;
    logic [N_BTN-1:0]   clear;
    logic [N_BTN-1:0]   drop;
    logic [BTN_MAX-1:0] pend_ext;
    logic [3:0]         ptr_ext;
    rr_pick_t           pick;

`ifdef BTN_REPEAT_EN
    logic [N_BTN-1:0] rep_pulse;

    for (genvar g = 0; g < N_BTN; g++) begin : g_rep
        btn_repeat_timer #(
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        ) u_rep (
            .clk       (clk),
            .rst       (rst),
            .level     (btn_level[g]),
            .rep_pulse (rep_pulse[g])
        );
    end
`else
    logic unused_level;
    assign unused_level = ^btn_level;
`endif

    always_comb begin
`ifdef BTN_REPEAT_EN
        req = btn_pulse | rep_pulse;
`else
        req = btn_pulse;
`endif
        pend_ext               = '0;
        pend_ext[N_BTN-1:0]    = pending_q;
        ptr_ext                = '0;
        ptr_ext[ID_W-1:0]      = rr_ptr_q;
        pick                   = rr_pick(pend_ext, ptr_ext, N_BTN);

        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        clear       = '0;

        case (state_q)
            IDLE: begin
                if (pick.any) begin
                    clear       = {{(N_BTN-1){1'b0}}, 1'b1} << pick.idx;
                    evt_id_d    = pick.idx[ID_W-1:0];
                    evt_valid_d = 1'b1;
                    state_d     = PRESENT;
                end
            end
            PRESENT: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = (evt_id_q == ID_W'(N_BTN - 1)) ? '0 : evt_id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A request on the bit being granted re-arms it rather than counting as a drop.
        drop      = req & pending_q & ~clear;
        pending_d = (pending_q & ~clear) | req;
        overrun_d = |drop;
        ovr_cnt_d = (overrun_d && ovr_cnt_q != 8'hFF) ? ovr_cnt_q + 8'd1 : ovr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign evt_valid   = evt_valid_q;
    assign evt_id      = evt_id_q;
    assign pending     = pending_q;
    assign evt_overrun = overrun_q;
    assign ovr_cnt     = ovr_cnt_q;

endmodule
